tick_countdown_timer: RTL and testbench

Programmable countdown timer driven by the one-cycle `clk_flag` strobe from the divide-by-six stage; it consumes that strobe as its only time base. Software-style `start`/`pause` pulses control a run/pause state machine. Every `PRESCALE` strobes the count decrements by one. Reaching zero produces a one-cycle `done` pulse. It sits directly downstream of the divider, in the same `sys_clk` domain.

---
 rtl/tick_countdown_timer_pkg.sv | 15 +
 rtl/tick_countdown_timer_prescaler.sv | 41 ++++
 rtl/tick_countdown_timer.sv | 129 ++++++++++++
 tb/tb_tick_countdown_timer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_countdown_timer_pkg.sv
// Shared definitions for the tick countdown timer: FSM state encodings
// and the prescaler counter width.
package timer_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Wide enough for any legal PRESCALE (1..65535).
    localparam int PRE_W = 16;

endpackage

// File: rtl/tick_countdown_timer_prescaler.sv
// tick_prescaler: counts clk_flag strobes (tick) while enabled and flags the
// strobe that completes a PRESCALE-long group. clr wins over counting.
module tick_prescaler
    import timer_defs::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic step
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] pre_cnt;

    // Prescaler count: clear on clr, wrap to 0 after the last strobe of a group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (tick && en) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_ONE;
            end
        end
    end

    // Step is combinational so the owner can act on the same edge.
    always_comb begin
        step = tick && en && (pre_cnt == PRE_LAST);
    end

endmodule

// File: rtl/tick_countdown_timer.sv
// tick_countdown_timer: programmable countdown driven by the clk_flag strobe.
// start loads and (re)starts, pause toggles RUN/PAUSED, done pulses once when
// the count reaches zero.
// Optional feature macro: TIMER_AUTO_RELOAD_EN -- a terminal decrement reloads
// the count from the last loaded value and keeps running (done still pulses).
//
// Handshake: start, pause and clk_flag are single-cycle pulses sampled on the
// rising edge of sys_clk; there is no back-pressure. When they coincide the
// priority is start > pause > clk_flag.
module tick_countdown_timer
    import timer_defs::*;
#(
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_flag,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt_val,
    output logic             busy,
    output logic             done,
    output state_t           dbg_state
);

`ifdef TIMER_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [CNT_W-1:0] reload_q, reload_nxt;
    logic             done_q, done_nxt;
    logic             pre_clr, pre_en, step;

    // The prescaler only advances in RUN when no higher-priority event is present.
    assign pre_clr = start;
    assign pre_en  = (state == ST_RUN) && !pause && !start;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (clk_flag),
        .step  (step)
    );

    // State register plus the registered count, reload value and done pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_q    <= cnt_nxt;
            reload_q <= reload_nxt;
            done_q   <= done_nxt;
        end
    end

    // Next-state and datapath update, start first, then pause, then step.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_q;
        reload_nxt = reload_q;
        done_nxt   = 1'b0;
        if (start) begin
            cnt_nxt    = load_val;
            reload_nxt = load_val;
            if (load_val == '0) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (pause) begin
                        state_nxt = ST_PAUSED;
                    end else if (step) begin
                        if (cnt_q == CNT_ONE) begin
                            done_nxt = 1'b1;
                            if (AUTO_RELOAD && (reload_q != '0)) begin
                                cnt_nxt = reload_q;
                            end else begin
                                cnt_nxt   = '0;
                                state_nxt = ST_DONE;
                            end
                        end else if (cnt_q != '0) begin
                            cnt_nxt = cnt_q - CNT_ONE;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (pause) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        cnt_val   = cnt_q;
        done      = done_q;
        busy      = (state == ST_RUN) || (state == ST_PAUSED);
        dbg_state = state;
    end

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer: two instances (PRESCALE=2 and
// PRESCALE=1) share clock and reset; strobes arrive every 6 clocks.
module tb_tick_countdown_timer;
    import timer_defs::*;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    logic        flag2, start2, pause2, busy2, done2;
    logic [15:0] load2, cnt2;
    state_t      st2;
    logic        flag1, start1, pause1, busy1, done1;
    logic [15:0] load1, cnt1;
    state_t      st1;

    int tests = 0;
    int fails = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    int base;

    always #5 sys_clk = ~sys_clk;

    tick_countdown_timer #(.CNT_W(16), .PRESCALE(2)) u_p2 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_flag  (flag2),
        .start     (start2),
        .pause     (pause2),
        .load_val  (load2),
        .cnt_val   (cnt2),
        .busy      (busy2),
        .done      (done2),
        .dbg_state (st2)
    );

    tick_countdown_timer #(.CNT_W(16), .PRESCALE(1)) u_p1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_flag  (flag1),
        .start     (start1),
        .pause     (pause1),
        .load_val  (load1),
        .cnt_val   (cnt1),
        .busy      (busy1),
        .done      (done1),
        .dbg_state (st1)
    );

    // Count done pulses away from the active edge.
    always @(negedge sys_clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One divider period: five quiet clocks, then one strobe clock; start/pause
    // may ride on the strobe cycle to create collisions.
    task automatic strobe(input int which, input logic st, input logic pa, input logic [15:0] lv);
        repeat (5) tick();
        if (which == 1) begin
            flag1 = 1'b1; start1 = st; pause1 = pa;
            if (st) load1 = lv;
        end else begin
            flag2 = 1'b1; start2 = st; pause2 = pa;
            if (st) load2 = lv;
        end
        tick();
        flag1 = 1'b0; start1 = 1'b0; pause1 = 1'b0;
        flag2 = 1'b0; start2 = 1'b0; pause2 = 1'b0;
    endtask

    task automatic pulse_start(input int which, input logic [15:0] lv);
        if (which == 1) begin start1 = 1'b1; load1 = lv; end
        else            begin start2 = 1'b1; load2 = lv; end
        tick();
        start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic pulse_pause(input int which);
        if (which == 1) pause1 = 1'b1;
        else            pause2 = 1'b1;
        tick();
        pause1 = 1'b0; pause2 = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        flag1 = 0; start1 = 0; pause1 = 0; load1 = '0;
        flag2 = 0; start2 = 0; pause2 = 0; load2 = '0;

        // Reset state
        repeat (3) tick();
        check("rst_cnt",   32'(cnt2), 32'd0);
        check("rst_busy",  32'(busy2), 32'd0);
        check("rst_done",  32'(done2), 32'd0);
        check("rst_state", 32'(st2), 32'(ST_IDLE));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();

        // One-shot, PRESCALE=2, load 3: done after 6 strobes
        pulse_start(2, 16'd3);
        check("os_load_cnt",  32'(cnt2), 32'd3);
        check("os_load_busy", 32'(busy2), 32'd1);
        check("os_load_done", 32'(done2), 32'd0);
        for (int s = 1; s <= 6; s++) begin
            strobe(2, 1'b0, 1'b0, 16'd0);
            check("os_cnt",  32'(cnt2), 32'(3 - s / 2));
            check("os_done", 32'(done2), (s == 6) ? 32'd1 : 32'd0);
        end
        tick();
        check("os_after_done",  32'(done2), 32'd0);
        check("os_after_busy",  32'(busy2), 32'd0);
        check("os_after_cnt",   32'(cnt2), 32'd0);
        check("os_after_state", 32'(st2), 32'(ST_IDLE));
        check("os_pulses",      32'(done_cnt2), 32'd1);

        // Pause, PRESCALE=1, load 4
        pulse_start(1, 16'd4);
        strobe(1, 1'b0, 1'b0, 16'd0);
        strobe(1, 1'b0, 1'b0, 16'd0);
        check("pz_before", 32'(cnt1), 32'd2);
        pulse_pause(1);
        check("pz_state", 32'(st1), 32'(ST_PAUSED));
        check("pz_busy",  32'(busy1), 32'd1);
        for (int s = 0; s < 5; s++) begin
            strobe(1, 1'b0, 1'b0, 16'd0);
            check("pz_hold", 32'(cnt1), 32'd2);
        end
        pulse_pause(1);
        check("pz_resume_state", 32'(st1), 32'(ST_RUN));
        check("pz_resume_cnt",   32'(cnt1), 32'd2);
        strobe(1, 1'b0, 1'b0, 16'd0);
        check("pz_cnt1",  32'(cnt1), 32'd1);
        check("pz_done0", 32'(done1), 32'd0);
        strobe(1, 1'b0, 1'b0, 16'd0);
        check("pz_cnt0",  32'(cnt1), 32'd0);
        check("pz_done1", 32'(done1), 32'd1);
        tick();
        check("pz_end_busy", 32'(busy1), 32'd0);
        check("pz_end_done", 32'(done1), 32'd0);
        check("pz_pulses",   32'(done_cnt1), 32'd1);

        // Zero load: done on the first cycle, busy never high
        pulse_start(1, 16'd0);
        check("zl_done",  32'(done1), 32'd1);
        check("zl_cnt",   32'(cnt1), 32'd0);
        check("zl_busy",  32'(busy1), 32'd0);
        tick();
        check("zl_done_drop", 32'(done1), 32'd0);
        check("zl_busy_after", 32'(busy1), 32'd0);
        check("zl_pulses", 32'(done_cnt1), 32'd2);

        // Pause in IDLE is ignored
        pulse_pause(1);
        check("idle_pause_state", 32'(st1), 32'(ST_IDLE));
        check("idle_pause_busy",  32'(busy1), 32'd0);

        // start coinciding with the terminal strobe wins, no done
        pulse_start(2, 16'd1);
        strobe(2, 1'b0, 1'b0, 16'd0);
        check("col_mid_cnt", 32'(cnt2), 32'd1);
        strobe(2, 1'b1, 1'b0, 16'd5);
        check("col_cnt",  32'(cnt2), 32'd5);
        check("col_done", 32'(done2), 32'd0);
        check("col_busy", 32'(busy2), 32'd1);
        tick();
        check("col_pulses", 32'(done_cnt2), 32'd1);

        // pause + clk_flag: pauses without advancing, prescaler kept
        strobe(2, 1'b0, 1'b0, 16'd0);
        strobe(2, 1'b0, 1'b1, 16'd0);
        check("pf_cnt",   32'(cnt2), 32'd5);
        check("pf_state", 32'(st2), 32'(ST_PAUSED));
        pulse_pause(2);
        check("pf_resume", 32'(st2), 32'(ST_RUN));
        strobe(2, 1'b0, 1'b0, 16'd0);
        check("pf_step", 32'(cnt2), 32'd4);

        // Mid-run reset, asynchronous to the clock
        pulse_start(1, 16'd9);
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("mr_cnt2",  32'(cnt2), 32'd0);
        check("mr_busy2", 32'(busy2), 32'd0);
        check("mr_done2", 32'(done2), 32'd0);
        check("mr_cnt1",  32'(cnt1), 32'd0);
        check("mr_busy1", 32'(busy1), 32'd0);
        #3;
        sys_rst_n = 1'b1;
        tick();
        for (int s = 0; s < 12; s++) strobe(2, 1'b0, 1'b0, 16'd0);
        check("mr_no_done", 32'(done_cnt2), 32'd1);
        check("mr_idle",    32'(busy2), 32'd0);
        check("mr_state",   32'(st2), 32'(ST_IDLE));

        // Terminal behaviour with PRESCALE=1, load 2
        base = done_cnt1;
        pulse_start(1, 16'd2);
        strobe(1, 1'b0, 1'b0, 16'd0);
        check("ar_cnt_a",  32'(cnt1), 32'd1);
        check("ar_done_a", 32'(done1), 32'd0);
        strobe(1, 1'b0, 1'b0, 16'd0);
`ifdef TIMER_AUTO_RELOAD_EN
        check("ar_cnt_b",  32'(cnt1), 32'd2);
        check("ar_done_b", 32'(done1), 32'd1);
        check("ar_busy_b", 32'(busy1), 32'd1);
        strobe(1, 1'b0, 1'b0, 16'd0);
        check("ar_cnt_c",  32'(cnt1), 32'd1);
        check("ar_done_c", 32'(done1), 32'd0);
        strobe(1, 1'b0, 1'b0, 16'd0);
        check("ar_cnt_d",  32'(cnt1), 32'd2);
        check("ar_done_d", 32'(done1), 32'd1);
        tick();
        check("ar_busy_e", 32'(busy1), 32'd1);
        check("ar_pulses", 32'(done_cnt1), 32'(base + 2));
`else
        check("ar_cnt_b",  32'(cnt1), 32'd0);
        check("ar_done_b", 32'(done1), 32'd1);
        tick();
        check("ar_busy_e", 32'(busy1), 32'd0);
        check("ar_done_e", 32'(done1), 32'd0);
        check("ar_pulses", 32'(done_cnt1), 32'(base + 1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
